// File: rtl/test7seg_pkg.sv
// Shared types and constants for the minutes:seconds BCD timer.
package test7seg_pkg;

   typedef enum logic {
      ST_STOPPED = 1'b0,
      ST_RUNNING = 1'b1
   } state_e;

   typedef logic [3:0] bcd_t;

   localparam bcd_t       SEC_TENS_MAX = 4'd5;
   localparam bcd_t       ONES_MAX     = 4'd9;
   localparam logic [5:0] SEC_MAX      = 6'd59;

   // Binary 0..59 to {tens, ones}; at most five subtract-by-ten steps.
   function automatic logic [7:0] bin_to_bcd(input logic [5:0] bin);
      logic [5:0] rem;
      bcd_t       tens;
      rem  = bin;
      tens = '0;
      for (int i = 0; i < 5; i++) begin
         if (rem >= 6'd10) begin
            rem  = rem - 6'd10;
            tens = tens + 4'd1;
         end
      end
      return {tens, rem[3:0]};
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit 0..MAX with clear > load > increment priority; carry is
// raised when an increment rolls the digit from MAX back to 0.
module bcd_digit
   import test7seg_pkg::*;
#(
   parameter bcd_t MAX = ONES_MAX
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       clr,
   input  logic       ld,
   input  logic [3:0] ld_val,
   output logic [3:0] value,
   output logic       carry
);

   bcd_t value_q;
   bcd_t value_d;

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (ld) begin
         value_d = ld_val;
      end else if (inc) begin
         value_d = (value_q == MAX) ? 4'd0 : value_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign carry = inc && (value_q == MAX);

endmodule

// File: rtl/min_sec_bcd_counter.sv
// Run/stop minutes:seconds timer (00:00..59:59) feeding the HEX3..HEX0 decoders.
//   state      | meaning
//   ST_STOPPED | prescaler frozen, digits hold, waiting for start
//   ST_RUNNING | prescaler counts, one digit increment per DIVISOR cycles
module min_sec_bcd_counter
   import test7seg_pkg::*;
#(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 1
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       load,
   input  logic [5:0] load_sec,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       tick,
   output logic       wrap,
   output logic       running
);

   localparam int DIVISOR = CLK_HZ / TICK_HZ;
   localparam int PW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [PW-1:0] DIV_M1 = PW'(DIVISOR - 1);

   generate
      if (DIVISOR < 2) begin : g_bad_divisor
         $error("min_sec_bcd_counter: CLK_HZ/TICK_HZ must be at least 2");
      end
   endgenerate

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   logic          wrap_q, wrap_d;

   logic          cnt_ev;
   logic          load_ok;
   logic          inc_en;
   logic [7:0]    ld_bcd;
   logic          so_carry, st_carry, mo_carry, mt_carry;

   // A valid load steals the count event so the preset value is what shows.
   always_comb begin
      cnt_ev  = (state_q == ST_RUNNING) && (presc_q == DIV_M1);
      load_ok = load && (load_sec <= SEC_MAX);
      inc_en  = cnt_ev && !clear && !load_ok;
      ld_bcd  = bin_to_bcd(load_sec);
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tick_d  = inc_en;
      wrap_d  = mt_carry;
      if (clear || stop) begin
         state_d = ST_STOPPED;
      end else if (start) begin
         state_d = ST_RUNNING;
      end
      if (clear) begin
         presc_d = '0;
      end else if (state_q == ST_RUNNING) begin
         presc_d = cnt_ev ? '0 : presc_q + PW'(1);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_STOPPED;
         presc_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   bcd_digit #(.MAX(ONES_MAX)) u_sec_ones (
      .clk    (CLOCK_50),
      .rst_n  (RESET_N),
      .inc    (inc_en),
      .clr    (clear),
      .ld     (load_ok),
      .ld_val (ld_bcd[3:0]),
      .value  (sec_ones),
      .carry  (so_carry)
   );

   bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk    (CLOCK_50),
      .rst_n  (RESET_N),
      .inc    (so_carry),
      .clr    (clear),
      .ld     (load_ok),
      .ld_val (ld_bcd[7:4]),
      .value  (sec_tens),
      .carry  (st_carry)
   );

   bcd_digit #(.MAX(ONES_MAX)) u_min_ones (
      .clk    (CLOCK_50),
      .rst_n  (RESET_N),
      .inc    (st_carry),
      .clr    (clear),
      .ld     (1'b0),
      .ld_val (4'd0),
      .value  (min_ones),
      .carry  (mo_carry)
   );

   bcd_digit #(.MAX(SEC_TENS_MAX)) u_min_tens (
      .clk    (CLOCK_50),
      .rst_n  (RESET_N),
      .inc    (mo_carry),
      .clr    (clear),
      .ld     (1'b0),
      .ld_val (4'd0),
      .value  (min_tens),
      .carry  (mt_carry)
   );

   assign tick    = tick_q;
   assign wrap    = wrap_q;
   assign running = (state_q == ST_RUNNING);

endmodule
